rx_frame_sync: RTL and testbench

Parametrised frame synchroniser and byte packer for the receive chain. It sits after the symbol decision stage (BPSK/QPSK hard decisions at the symbol rate in the 1.024 MHz domain). It hunts for a configurable sync word with a Hamming-distance tolerance and resolves BPSK 180° and QPSK 90° phase ambiguity from the sync match. It then de-rotates and packs the following payload symbols into an AXI-Stream byte frame carrying tuser (start of frame) and tlast (end of frame).

---
 rtl/rx_frame_sync_pkg.sv | 27 ++
 rtl/rx_frame_sync_corr.sv | 44 ++++
 rtl/rx_frame_sync.sv | 165 ++++++++++++++++
 tb/tb_rx_frame_sync.sv | 340 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rx_frame_sync_pkg.sv
// Shared encodings and helpers for the receive-chain frame synchroniser.
// rot_dibit is also used by the phase-ambiguity logic elsewhere in the receiver.
package rx_frame_sync_pkg;

  localparam logic MODE_BPSK = 1'b0;
  localparam logic MODE_QPSK = 1'b1;

  localparam logic [0:0] ST_HUNT    = 1'b0;
  localparam logic [0:0] ST_PAYLOAD = 1'b1;

  typedef struct packed {
    logic [7:0] data;
    logic       last;
    logic       user;
  } axis_byte_t;

  // Apply phase rotation Rk to a hard-decision dibit {I,Q}.
  function automatic logic [1:0] rot_dibit(input logic [1:0] k, input logic [1:0] dibit);
    case (k)
      2'd0:    rot_dibit = dibit;
      2'd1:    rot_dibit = {~dibit[0], dibit[1]};
      2'd2:    rot_dibit = ~dibit;
      default: rot_dibit = {dibit[0], ~dibit[1]};
    endcase
  endfunction

endpackage

// File: rtl/rx_frame_sync_corr.sv
// One rotation candidate of the sync correlator: rotated shift register,
// Hamming distance to the sync word, threshold compare on the incoming symbol.
module rx_frame_sync_corr
  import rx_frame_sync_pkg::*;
#(
  parameter int unsigned       SYNC_W    = 32,
  parameter logic [SYNC_W-1:0] SYNC_WORD = SYNC_W'(32'h1ACF_FC1D),
  parameter int unsigned       ERR_W     = 4,
  parameter logic [1:0]        K         = 2'd0,
  localparam int unsigned      DIST_W    = $clog2(SYNC_W + 1)
) (
  input  logic              clk_1M024,
  input  logic              rst_1M024,
  input  logic              sym_valid,
  input  logic [1:0]        sym_data,
  input  logic              mode,
  input  logic [ERR_W-1:0]  sync_thresh,
  output logic              match_c,
  output logic [DIST_W-1:0] dist_c
);

  logic [SYNC_W-1:0] sr_q;
  logic [SYNC_W-1:0] sr_nxt;
  logic [1:0]        rot;

  always_comb begin
    rot = rot_dibit(K, sym_data);
    if (mode == MODE_QPSK) sr_nxt = {sr_q[SYNC_W-3:0], rot};
    else                   sr_nxt = {sr_q[SYNC_W-2:0], rot[1]};
  end

  always_ff @(posedge clk_1M024 or negedge rst_1M024) begin
    if (!rst_1M024)     sr_q <= '0;
    else if (sym_valid) sr_q <= sr_nxt;
  end

  // Distance is taken on the post-shift value so a match lands on the completing symbol.
  always_comb begin
    dist_c = '0;
    for (int i = 0; i < SYNC_W; i++) dist_c = dist_c + DIST_W'(sr_nxt[i] ^ SYNC_WORD[i]);
    match_c = sym_valid && (32'(dist_c) <= 32'(sync_thresh));
  end

endmodule

// File: rtl/rx_frame_sync.sv
// Frame synchroniser and byte packer: sync hunt with phase-ambiguity resolution,
// de-rotation of payload symbols and a single-entry AXI-Stream byte output.
module rx_frame_sync
  import rx_frame_sync_pkg::*;
#(
  parameter int unsigned       SYNC_W    = 32,
  parameter logic [SYNC_W-1:0] SYNC_WORD = SYNC_W'(32'h1ACF_FC1D),
  parameter int unsigned       LEN_W     = 8,
  parameter int unsigned       ERR_W     = 4
) (
  input  logic             clk_1M024,
  input  logic             rst_1M024,
  input  logic             sym_valid,
  input  logic [1:0]       sym_data,
  input  logic             mode,
  input  logic [ERR_W-1:0] sync_thresh,
  input  logic [LEN_W-1:0] frame_len,
  output logic [7:0]       m_tdata,
  output logic             m_tvalid,
  input  logic             m_tready,
  output logic             m_tlast,
  output logic             m_tuser,
  output logic             locked,
  output logic [1:0]       rot_idx,
  output logic             sync_pulse,
  output logic             ovf
);

  localparam int unsigned DIST_W = $clog2(SYNC_W + 1);
  localparam int unsigned BIT_W  = 4;

  logic [3:0]        match_c;
  logic [DIST_W-1:0] corr_dist_unused [4];

  for (genvar k = 0; k < 4; k++) begin : g_corr
    rx_frame_sync_corr #(
      .SYNC_W   (SYNC_W),
      .SYNC_WORD(SYNC_WORD),
      .ERR_W    (ERR_W),
      .K        (2'(k))
    ) u_corr (
      .clk_1M024  (clk_1M024),
      .rst_1M024  (rst_1M024),
      .sym_valid  (sym_valid),
      .sym_data   (sym_data),
      .mode       (mode),
      .sync_thresh(sync_thresh),
      .match_c    (match_c[k]),
      .dist_c     (corr_dist_unused[k])
    );
  end

  logic [0:0]       state_q, state_nxt;
  logic             mode_q, mode_nxt;
  logic [LEN_W-1:0] len_q, len_nxt;
  logic [LEN_W-1:0] byte_q, byte_nxt;
  logic [BIT_W-1:0] bit_q, bit_nxt;
  logic [7:0]       acc_q, acc_nxt;
  axis_byte_t       out_q, out_nxt;
  logic [1:0]       rot_nxt, sel_k, rot_d;
  logic             valid_nxt, ovf_nxt, pulse_nxt, found, last_byte;

  always_ff @(posedge clk_1M024 or negedge rst_1M024) begin
    if (!rst_1M024) state_q <= ST_HUNT;
    else            state_q <= state_nxt;
  end

  always_comb begin
    state_nxt = state_q;
    mode_nxt  = mode_q;
    len_nxt   = len_q;
    rot_nxt   = rot_idx;
    byte_nxt  = byte_q;
    bit_nxt   = bit_q;
    acc_nxt   = acc_q;
    out_nxt   = out_q;
    valid_nxt = m_tvalid && !m_tready;
    ovf_nxt   = ovf;
    pulse_nxt = 1'b0;
    found     = 1'b0;
    sel_k     = 2'd0;
    rot_d     = rot_dibit(rot_idx, sym_data);
    last_byte = (byte_q == len_q - LEN_W'(1));

    // Lowest matching candidate wins; odd rotations are meaningless in BPSK.
    for (int k = 3; k >= 0; k--) begin
      if (match_c[k] && (mode == MODE_QPSK || (k % 2) == 0)) begin
        found = 1'b1;
        sel_k = 2'(k);
      end
    end

    case (state_q)
      ST_HUNT: begin
        if (found) begin
          rot_nxt   = sel_k;
          mode_nxt  = mode;
          len_nxt   = (frame_len == '0) ? LEN_W'(1) : frame_len;
          byte_nxt  = '0;
          bit_nxt   = '0;
          pulse_nxt = 1'b1;
          state_nxt = ST_PAYLOAD;
        end
      end
      default: begin
        if (sym_valid) begin
          if (mode_q == MODE_QPSK) begin
            acc_nxt = {acc_q[5:0], rot_d};
            bit_nxt = bit_q + BIT_W'(2);
          end else begin
            acc_nxt = {acc_q[6:0], rot_d[1]};
            bit_nxt = bit_q + BIT_W'(1);
          end
          if (bit_nxt == BIT_W'(8)) begin
            bit_nxt  = '0;
            byte_nxt = byte_q + LEN_W'(1);
            // A stalled pending byte keeps the slot; the new byte is lost but still counted.
            if (!m_tvalid || m_tready) begin
              out_nxt.data = acc_nxt;
              out_nxt.last = last_byte;
              out_nxt.user = (byte_q == '0);
              valid_nxt    = 1'b1;
            end else begin
              ovf_nxt = 1'b1;
            end
            if (last_byte) state_nxt = ST_HUNT;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk_1M024 or negedge rst_1M024) begin
    if (!rst_1M024) begin
      mode_q     <= MODE_BPSK;
      len_q      <= '0;
      byte_q     <= '0;
      bit_q      <= '0;
      acc_q      <= '0;
      out_q      <= '0;
      m_tvalid   <= 1'b0;
      ovf        <= 1'b0;
      sync_pulse <= 1'b0;
      locked     <= 1'b0;
      rot_idx    <= 2'd0;
    end else begin
      mode_q     <= mode_nxt;
      len_q      <= len_nxt;
      byte_q     <= byte_nxt;
      bit_q      <= bit_nxt;
      acc_q      <= acc_nxt;
      out_q      <= out_nxt;
      m_tvalid   <= valid_nxt;
      ovf        <= ovf_nxt;
      sync_pulse <= pulse_nxt;
      locked     <= (state_nxt == ST_PAYLOAD);
      rot_idx    <= rot_nxt;
    end
  end

  assign m_tdata = out_q.data;
  assign m_tlast = out_q.last;
  assign m_tuser = out_q.user;

endmodule

// File: tb/tb_rx_frame_sync.sv
// Randomised scoreboard bench for rx_frame_sync against a symbol-level reference model.
module tb_rx_frame_sync;

  localparam int unsigned SYNC_W    = 32;
  localparam logic [31:0] SYNC_WORD = 32'h1ACF_FC1D;

  logic       clk_1M024 = 1'b0;
  logic       rst_1M024 = 1'b0;
  logic       sym_valid = 1'b0;
  logic [1:0] sym_data  = 2'b00;
  logic       mode      = 1'b0;
  logic [3:0] sync_thresh = 4'd0;
  logic [7:0] frame_len = 8'd1;
  logic [7:0] m_tdata;
  logic       m_tvalid;
  logic       m_tready  = 1'b1;
  logic       m_tlast;
  logic       m_tuser;
  logic       locked;
  logic [1:0] rot_idx;
  logic       sync_pulse;
  logic       ovf;

  always #5 clk_1M024 = ~clk_1M024;

  rx_frame_sync #(.SYNC_W(SYNC_W), .SYNC_WORD(SYNC_WORD), .LEN_W(8), .ERR_W(4)) dut (
    .clk_1M024  (clk_1M024),
    .rst_1M024  (rst_1M024),
    .sym_valid  (sym_valid),
    .sym_data   (sym_data),
    .mode       (mode),
    .sync_thresh(sync_thresh),
    .frame_len  (frame_len),
    .m_tdata    (m_tdata),
    .m_tvalid   (m_tvalid),
    .m_tready   (m_tready),
    .m_tlast    (m_tlast),
    .m_tuser    (m_tuser),
    .locked     (locked),
    .rot_idx    (rot_idx),
    .sync_pulse (sync_pulse),
    .ovf        (ovf)
  );

  int checks = 0;
  int errors = 0;

  // Reference model state: per-rotation bit history, payload bit collector, output slot.
  bit         hist[4][$];
  bit         pay_bits[$];
  bit         m_hunt;
  bit [1:0]   m_rot;
  bit         m_mode;
  int         m_len;
  int         m_idx;
  bit         m_pulse;
  bit         m_ovf;
  bit         slot_v;
  logic [9:0] exp_q[$];
  logic [9:0] rx_log[$];
  int         dut_syncs = 0;
  int         dut_frames = 0;
  int         ready_pct = 100;
  int         gap_pct = 10;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic bit [1:0] spec_rot(input int k, input bit [1:0] d);
    case (k)
      0:       return d;
      1:       return {~d[0], d[1]};
      2:       return ~d;
      default: return {d[0], ~d[1]};
    endcase
  endfunction

  function automatic int distance(input int k);
    int n = 0;
    for (int i = 0; i < SYNC_W; i++)
      if (hist[k][i] != SYNC_WORD[SYNC_W-1-i]) n++;
    return n;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 4; k++) begin
      hist[k].delete();
      for (int i = 0; i < SYNC_W; i++) hist[k].push_back(1'b0);
    end
    pay_bits.delete();
    exp_q.delete();
    m_hunt = 1'b1; m_rot = 2'd0; m_mode = 1'b0; m_len = 1; m_idx = 0;
    m_pulse = 1'b0; m_ovf = 1'b0; slot_v = 1'b0;
  endtask

  // Advance the model by one clock edge using the inputs held across that edge.
  task automatic model_step();
    bit       can_load;
    bit       found;
    bit [1:0] d;
    bit [7:0] b;
    bit       last;
    can_load = !slot_v || m_tready;
    if (slot_v && m_tready) slot_v = 1'b0;
    m_pulse = 1'b0;
    if (sym_valid) begin
      for (int k = 0; k < 4; k++) begin
        d = spec_rot(k, sym_data);
        hist[k].push_back(d[1]);
        if (mode) hist[k].push_back(d[0]);
        while (hist[k].size() > SYNC_W) void'(hist[k].pop_front());
      end
      if (m_hunt) begin
        found = 1'b0;
        for (int k = 0; k < 4; k++) begin
          if (!found && (mode || (k % 2) == 0) && distance(k) <= int'(sync_thresh)) begin
            found = 1'b1; m_rot = 2'(k);
          end
        end
        if (found) begin
          m_hunt = 1'b0; m_pulse = 1'b1; m_mode = mode;
          m_len = (frame_len == 0) ? 1 : int'(frame_len);
          m_idx = 0; pay_bits.delete();
        end
      end else begin
        d = spec_rot(m_rot, sym_data);
        pay_bits.push_back(d[1]);
        if (m_mode) pay_bits.push_back(d[0]);
        if (pay_bits.size() == 8) begin
          b = 8'h00;
          for (int i = 0; i < 8; i++) b = {b[6:0], pay_bits[i]};
          pay_bits.delete();
          last = (m_idx == m_len - 1);
          if (can_load) begin
            exp_q.push_back({b, last, m_idx == 0});
            slot_v = 1'b1;
          end else begin
            m_ovf = 1'b1;
          end
          m_idx++;
          if (last) m_hunt = 1'b1;
        end
      end
    end
  endtask

  // Monitor: per-cycle status against the model, byte scoreboard on every handshake.
  always @(negedge clk_1M024) begin
    if (rst_1M024) begin
      chk("locked", int'(locked), int'(!m_hunt));
      chk("sync_pulse", int'(sync_pulse), int'(m_pulse));
      chk("rot_idx", int'(rot_idx), int'(m_rot));
      chk("ovf", int'(ovf), int'(m_ovf));
      if (sync_pulse) dut_syncs++;
      if (m_tvalid && m_tready) begin
        rx_log.push_back({m_tdata, m_tlast, m_tuser});
        if (m_tlast) dut_frames++;
        if (exp_q.size() == 0) chk("unexpected_byte", int'({m_tdata, m_tlast, m_tuser}), -1);
        else chk("byte", int'({m_tdata, m_tlast, m_tuser}), int'(exp_q.pop_front()));
      end
    end
  end

  task automatic cyc(input bit v, input bit [1:0] d);
    sym_valid = v;
    sym_data  = d;
    m_tready  = ($urandom_range(99) < ready_pct);
    @(posedge clk_1M024);
    model_step();
    #1;
  endtask

  task automatic sym(input bit [1:0] d);
    while ($urandom_range(99) < gap_pct) cyc(1'b0, 2'($urandom));
    cyc(1'b1, d);
  endtask

  // Transmit nbits of w MSB-first so that rotation r at the receiver restores them.
  task automatic send_word(input logic [31:0] w, input int nbits, input bit md, input int r);
    if (md) begin
      for (int i = nbits - 1; i > 0; i -= 2) sym(spec_rot((4 - r) % 4, {w[i], w[i-1]}));
    end else begin
      for (int i = nbits - 1; i >= 0; i--) sym({(r == 2) ? ~w[i] : w[i], 1'($urandom)});
    end
  endtask

  task automatic send_frame(input bit md, input int r, input int len, input int th,
                            input logic [31:0] errmask, input logic [7:0] bytes[$]);
    mode = md; frame_len = 8'(len); sync_thresh = 4'(th);
    send_word(SYNC_WORD ^ errmask, SYNC_W, md, r);
    foreach (bytes[i]) send_word({24'h0, bytes[i]}, 8, md, r);
  endtask

  task automatic drain(input int n);
    int save = ready_pct;
    ready_pct = 100;
    repeat (n) cyc(1'b0, 2'b00);
    ready_pct = save;
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_tvalid"}, int'(m_tvalid), 0);
    chk({tag, "_tdata"}, int'(m_tdata), 0);
    chk({tag, "_tlast_tuser"}, int'({m_tlast, m_tuser}), 0);
    chk({tag, "_locked"}, int'(locked), 0);
    chk({tag, "_pulse_rot_ovf"}, int'({sync_pulse, rot_idx, ovf}), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] bq[$];
    int s0, f0;
    model_reset();
    repeat (2) @(posedge clk_1M024);
    #1;
    chk_zero_outputs("reset");
    rst_1M024 = 1'b1;

    // BPSK, exact sync, two bytes
    rx_log.delete(); s0 = dut_syncs; f0 = dut_frames;
    bq = '{8'hA5, 8'h3C};
    send_frame(1'b0, 0, 2, 0, 32'h0, bq);
    drain(4);
    chk("t1_syncs", dut_syncs - s0, 1);
    chk("t1_frames", dut_frames - f0, 1);
    chk("t1_count", rx_log.size(), 2);
    chk("t1_b0", int'(rx_log[0]), int'({8'hA5, 1'b0, 1'b1}));
    chk("t1_b1", int'(rx_log[1]), int'({8'h3C, 1'b1, 1'b0}));
    chk("t1_unlocked", int'(locked), 0);

    // QPSK rotated by R1, three bytes
    rx_log.delete();
    bq = '{8'h11, 8'h22, 8'h33};
    send_frame(1'b1, 1, 3, 0, 32'h0, bq);
    drain(4);
    chk("t2_rot", int'(rot_idx), 1);
    chk("t2_count", rx_log.size(), 3);
    chk("t2_b0", int'(rx_log[0]), int'({8'h11, 1'b0, 1'b1}));
    chk("t2_b2", int'(rx_log[2]), int'({8'h33, 1'b1, 1'b0}));

    // Three bit errors: accepted at threshold 3, rejected at threshold 2
    rx_log.delete(); s0 = dut_syncs;
    bq = '{8'h5A};
    send_frame(1'b0, 0, 1, 3, 32'h8001_0010, bq);
    drain(4);
    chk("t3a_syncs", dut_syncs - s0, 1);
    chk("t3a_count", rx_log.size(), 1);
    rx_log.delete(); s0 = dut_syncs;
    send_frame(1'b0, 0, 1, 2, 32'h8001_0010, bq);
    drain(4);
    chk("t3b_syncs", dut_syncs - s0, 0);
    chk("t3b_count", rx_log.size(), 0);

    // Back-pressure across two byte completions
    rx_log.delete();
    mode = 1'b0; frame_len = 8'd3; sync_thresh = 4'd0;
    send_word(SYNC_WORD, SYNC_W, 1'b0, 2);
    ready_pct = 0;
    send_word(32'hC3, 8, 1'b0, 2);
    send_word(32'h7E, 8, 1'b0, 2);
    ready_pct = 100;
    send_word(32'h96, 8, 1'b0, 2);
    drain(4);
    chk("t4_ovf", int'(ovf), 1);
    chk("t4_count", rx_log.size(), 2);
    chk("t4_b0", int'(rx_log[0]), int'({8'hC3, 1'b0, 1'b1}));
    chk("t4_b2", int'(rx_log[1]), int'({8'h96, 1'b1, 1'b0}));

    // Reset mid-payload, then a fresh frame
    ready_pct = 70;
    mode = 1'b1; frame_len = 8'd4;
    send_word(SYNC_WORD, SYNC_W, 1'b1, 3);
    send_word(32'hE7, 8, 1'b1, 3);
    send_word(32'h0B, 4, 1'b1, 3);
    rst_1M024 = 1'b0;
    #1;
    chk_zero_outputs("midreset");
    model_reset();
    @(posedge clk_1M024);
    @(posedge clk_1M024);
    #1;
    rst_1M024 = 1'b1;
    ready_pct = 100;
    rx_log.delete(); f0 = dut_frames;
    bq = '{8'h4D, 8'hB2};
    send_frame(1'b1, 3, 2, 0, 32'h0, bq);
    drain(4);
    chk("t5_frames", dut_frames - f0, 1);
    chk("t5_count", rx_log.size(), 2);
    chk("t5_b0", int'(rx_log[0]), int'({8'h4D, 1'b0, 1'b1}));
    chk("t5_b1", int'(rx_log[1]), int'({8'hB2, 1'b1, 1'b0}));

    // Back-to-back single-byte frames
    rx_log.delete(); s0 = dut_syncs; gap_pct = 0;
    bq = '{8'h81};
    send_frame(1'b0, 0, 1, 0, 32'h0, bq);
    bq = '{8'h18};
    send_frame(1'b0, 0, 0, 0, 32'h0, bq);
    drain(4);
    chk("t6_syncs", dut_syncs - s0, 2);
    chk("t6_count", rx_log.size(), 2);
    chk("t6_b0", int'(rx_log[0]), int'({8'h81, 1'b1, 1'b1}));
    chk("t6_b1", int'(rx_log[1]), int'({8'h18, 1'b1, 1'b1}));

    // Randomised frames with noise, gaps, errors and back-pressure
    gap_pct = 20; ready_pct = 75;
    for (int f = 0; f < 30; f++) begin
      bit md;
      int r, len, nerr;
      logic [31:0] em;
      md = 1'($urandom);
      r = md ? int'($urandom_range(3)) : 2 * int'($urandom_range(1));
      len = int'($urandom_range(5));
      nerr = int'($urandom_range(4));
      em = 32'h0;
      for (int e = 0; e < nerr; e++) em[$urandom_range(31)] = 1'b1;
      mode = md;
      repeat ($urandom_range(6)) sym(2'($urandom));
      bq.delete();
      for (int i = 0; i < ((len == 0) ? 1 : len); i++) bq.push_back(8'($urandom));
      send_frame(md, r, len, int'($urandom_range(3)), em, bq);
    end
    drain(6);
    chk("scoreboard_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
